// File: rtl/nibble_add_seq.sv
// Nibble-serial adder controller: drives one 4-bit ripple stage per cycle,
// LSB nibble first, returning the W-bit sum, carry-out and signed overflow.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [3:0]      a_nib, b_nib;
  logic [4:0]      add5;
  logic [3:0]      low3;

  // Index is widened before scaling so the bit offset cannot overflow IW bits.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    add5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
    low3  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          sum_d[{idx_q, 2'b00} +: 4] = add5[3:0];
          carry_d = add5[4];
          if (idx_q == IW'(NIBBLES - 1)) begin
            cout_d  = add5[4];
            ovf_d   = low3[3] ^ add5[4];
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule
